output_drainer: RTL
===================

Name: output_drainer

Overview:
- Reverse direction of the output filler: parallel-loads one completed 8x8x5 sub-pixel result block (40 words x 64 bits = 2560 bits).
- Streams the block out as 64-bit words, one per accepted cycle, over a valid/ready handshake.
- Sits between the interpolation output buffer and the downstream memory/bus writer.
- Word order matches filler fill order: the oldest word pushed into the filler is emitted first.

Parameters:
- WORD_W, 64, bits per output word.
- NUM_WORDS, 40, words per block (8 rows x 5 pixel planes).
- IDX_W, 6, width of word index; must satisfy 2^IDX_W >= NUM_WORDS.

Ports:
- clock  input  1  single system clock; all state updates on posedge.
- reset_L  input  1  asynchronous, active-low reset.
- load_L  input  1  active-low block load request.
- in  input  WORD_W*NUM_WORDS  parallel block; word k = in[(k+1)*WORD_W-1 -: WORD_W].
- load_ack  output  1  one-cycle pulse: load accepted at the preceding edge.
- busy  output  1  high while a block is held (DRAIN state).
- out  output  WORD_W  current output word.
- out_valid  output  1  out holds a valid word.
- out_ready  input  1  downstream accepts the word when high with out_valid.
- out_last  output  1  high with out_valid on the final word of the block.
- word_idx  output  IDX_W  index (0..NUM_WORDS-1) of the word currently on out.

Behaviour:
- Reset is asynchronous on negedge reset_L, with no clock required:
  - state=IDLE; block store=0; out=0; out_valid=0; out_last=0; busy=0; load_ack=0; word_idx=0.
- Reset mid-drain discards the block; no partial words are emitted after reset deassertion.
- States:
  - IDLE: out_valid=0, busy=0. load_L=0 at a posedge -> capture in, word_idx=0, go to DRAIN, load_ack=1 next cycle.
  - DRAIN: out_valid=1, busy=1. Emission sequence: first word is in word NUM_WORDS-1 (in[2559:2496]); word_idx=0 maps to that word; word_idx=n presents in word NUM_WORDS-1-n; last is in word 0.
- Transfer occurs on a posedge with out_valid=1 and out_ready=1; word_idx then increments by 1.
- While out_valid=1 and out_ready=0: out, out_last and word_idx hold stable; no word is skipped or repeated.
- out_last = (word_idx == NUM_WORDS-1) while in DRAIN.
- Last transfer (out_last=1 and out_ready=1):
  - With load_L=1: go to IDLE; out_valid=0 next cycle.
  - With load_L=0 in the same cycle: back-to-back reload; capture the new block, word_idx=0, stay in DRAIN, out_valid stays 1, load_ack=1. Zero bubble.
- load_L=0 in DRAIN other than on the last-transfer cycle: ignored; load_ack stays 0. The block store is never overwritten mid-drain.
- Latency: load edge -> first word valid immediately after that edge (1 cycle). Full block with out_ready held high = NUM_WORDS cycles.
- out is a registered output from the block store (shift-out or indexed mux); no combinational path from in to out.
- word_idx never exceeds NUM_WORDS-1. The counter wraps only via reload or the return to IDLE.

Decomposition:
- Shared package (interp_pkg):
  - WORD_W, NUM_WORDS, BLOCK_W = WORD_W*NUM_WORDS, IDX_W.
  - Drainer state enum {IDLE, DRAIN}.
  - The filler uses the same constants, so fill and drain sizes cannot diverge.
- One natural sub-module: block_shift_out, a parallel-load, shift-on-enable store of NUM_WORDS x WORD_W words that presents the top word.
- The FSM, counter and handshake logic stay in output_drainer.

Test Plan:
- Reset/idle: assert reset_L=0 asynchronously mid-cycle -> all outputs 0 immediately; release; out_ready=1, load_L=1 for 10 cycles -> out_valid stays 0.
- Basic drain: load block with word k = 64'h0000_0000_0000_00kk; hold out_ready=1 -> 40 consecutive words 0x27,0x26,...,0x00; word_idx runs 0..39; out_last only on 0x00; load_ack one pulse; out_valid drops after word 39.
- Backpressure: same block; out_ready toggles 1,0,0,1,... (pseudo-random seed 1) -> output sequence still exactly 0x27..0x00 with no duplicates; out stable on every ready=0 cycle.
- Back-to-back: block A (words 0xA0+k), then load_L=0 on A's last transfer with block B (0xB0+k) -> B's first word 0xB0+39 appears the next cycle with no out_valid gap; second load_ack.
- Ignored load: pulse load_L=0 at word_idx=10 with block C -> load_ack stays 0; remaining words are still from the original block.
- Reset mid-drain: reset at word_idx=20 -> out_valid=0 at once; after release, IDLE; a new load restarts at word_idx=0 with the new block's word 39.

Source files
------------

// File: rtl/interp_pkg.sv
// Constants and types shared by the interpolation output filler and drainer.
// The filler and drainer both size their blocks from here, so they always agree.
package interp_pkg;

    localparam int unsigned WORD_W    = 64;
    localparam int unsigned NUM_WORDS = 40;
    localparam int unsigned BLOCK_W   = WORD_W * NUM_WORDS;
    localparam int unsigned IDX_W     = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    typedef enum logic [0:0] {
        IDLE,
        DRAIN
    } drain_state_e;

endpackage

// File: rtl/block_shift_out.sv
// Parallel-load block store that shifts one word toward the top on each enable.
// The top word (highest-numbered input word) is presented on top.
module block_shift_out
    import interp_pkg::*;
(
    input  logic               clock,
    input  logic               reset_L,
    input  logic               load,
    input  logic               shift,
    input  logic [BLOCK_W-1:0] data,
    output logic [WORD_W-1:0]  top
);

    logic [BLOCK_W-1:0] store_q;

    // Load wins over shift so a back-to-back reload replaces the drained block.
    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            store_q <= '0;
        end else if (load) begin
            store_q <= data;
        end else if (shift) begin
            store_q <= {store_q[BLOCK_W-WORD_W-1:0], {WORD_W{1'b0}}};
        end
    end

    assign top = store_q[BLOCK_W-1 -: WORD_W];

endmodule

// File: rtl/output_drainer.sv
// Streams a parallel-loaded 40x64-bit result block out over valid/ready,
// newest-indexed input word first, with zero-bubble back-to-back reloads.
module output_drainer
    import interp_pkg::*;
(
    input  logic               clock,
    input  logic               reset_L,
    input  logic               load_L,
    input  logic [BLOCK_W-1:0] in,
    output logic               load_ack,
    output logic               busy,
    output logic [WORD_W-1:0]  out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [IDX_W-1:0]   word_idx
);

    drain_state_e     state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ack_q;
    logic             load_fire;
    logic             shift;
    logic             at_last;

    assign at_last = (idx_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        load_fire = 1'b0;
        shift     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!load_L) begin
                    load_fire = 1'b1;
                    state_d   = DRAIN;
                    idx_d     = '0;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    shift = 1'b1;
                    if (at_last) begin
                        idx_d = '0;
                        // A load request is honoured only on the final transfer.
                        if (!load_L) begin
                            load_fire = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ack_q   <= load_fire;
        end
    end

    block_shift_out u_store (
        .clock   (clock),
        .reset_L (reset_L),
        .load    (load_fire),
        .shift   (shift),
        .data    (in),
        .top     (out)
    );

    assign busy      = (state_q == DRAIN);
    assign out_valid = (state_q == DRAIN);
    assign out_last  = (state_q == DRAIN) && at_last;
    assign load_ack  = ack_q;
    assign word_idx  = idx_q;

endmodule
